// File: rtl/conv_encoder_framed_if.sv
// Handshake and status bundle for the framed convolutional encoder.
// The master side drives the frame controls and data; the slave side is the encoder.
interface conv_encoder_framed_if;
    logic        start_i;
    logic        enable_i;
    logic        d_in;
    logic        ready_o;
    logic        valid_o;
    logic [1:0]  d_out;
    logic        last_o;
    logic        busy_o;
    logic [15:0] bit_ct_o;

    modport master (
        output start_i, enable_i, d_in,
        input  ready_o, valid_o, d_out, last_o, busy_o, bit_ct_o
    );

    modport slave (
        input  start_i, enable_i, d_in,
        output ready_o, valid_o, d_out, last_o, busy_o, bit_ct_o
    );
endinterface

// File: rtl/conv_encoder_framed.sv
// Rate-1/2, K=3 convolutional encoder (generators 111/101) with framing.
// A frame is FRAME_LEN data bits followed by two zero tail bits that flush
// the shift register back to 00. Every output is driven straight from a register.
module conv_encoder_framed #(
    parameter int unsigned FRAME_LEN = 256
) (
    input logic                   clk,
    input logic                   rst,
    conv_encoder_framed_if.slave  bus
);

    typedef enum logic [1:0] {StIdle, StData, StTail} state_e;

    // Count value held just before the final data bit of a frame is accepted
    localparam logic [15:0] LastIdx = 16'(FRAME_LEN - 1);

    state_e      state_q;
    logic [1:0]  s_q;        // s_q[1] is the most recent previous input
    logic        tail_q;     // 0: first tail bit pending, 1: second tail bit pending
    logic [1:0]  d_out_q;
    logic        valid_q;
    logic        last_q;
    logic        ready_q;
    logic        busy_q;
    logic [15:0] bit_ct_q;

    // Frame FSM, encoder shift register and all registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= StIdle;
            s_q      <= 2'b00;
            tail_q   <= 1'b0;
            d_out_q  <= 2'b00;
            valid_q  <= 1'b0;
            last_q   <= 1'b0;
            ready_q  <= 1'b0;
            busy_q   <= 1'b0;
            bit_ct_q <= 16'd0;
        end else begin
            // Pulses by default; d_out holds its last value between symbols
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (bus.start_i) begin
                        state_q  <= StData;
                        s_q      <= 2'b00;
                        bit_ct_q <= 16'd0;
                        ready_q  <= 1'b1;
                        busy_q   <= 1'b1;
                    end
                end
                StData: begin
                    if (bus.enable_i) begin
                        d_out_q  <= {bus.d_in ^ s_q[1] ^ s_q[0], bus.d_in ^ s_q[0]};
                        s_q      <= {bus.d_in, s_q[1]};
                        valid_q  <= 1'b1;
                        bit_ct_q <= bit_ct_q + 16'd1;
                        if (bit_ct_q == LastIdx) begin
                            state_q <= StTail;
                            tail_q  <= 1'b0;
                            ready_q <= 1'b0;
                        end
                    end
                end
                StTail: begin
                    // Input forced to zero: symbol depends only on the register
                    d_out_q <= {s_q[1] ^ s_q[0], s_q[0]};
                    s_q     <= {1'b0, s_q[1]};
                    valid_q <= 1'b1;
                    if (tail_q) begin
                        last_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= StIdle;
                        tail_q  <= 1'b0;
                    end else begin
                        tail_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    ready_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.d_out    = d_out_q;
    assign bus.valid_o  = valid_q;
    assign bus.last_o   = last_q;
    assign bus.ready_o  = ready_q;
    assign bus.busy_o   = busy_q;
    assign bus.bit_ct_o = bit_ct_q;

endmodule

// File: tb/tb_conv_encoder_framed.sv
// Directed bench for conv_encoder_framed: a FRAME_LEN=4 instance for the golden,
// gapped, ignored-control and reset scenarios, and a FRAME_LEN=256 instance for
// back-to-back frames against a generator-polynomial reference.
module tb_conv_encoder_framed;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    conv_encoder_framed_if bus4 ();
    conv_encoder_framed_if bus256 ();

    conv_encoder_framed #(.FRAME_LEN(4)) u_dut4 (
        .clk (clk),
        .rst (rst),
        .bus (bus4)
    );

    conv_encoder_framed #(.FRAME_LEN(256)) u_dut256 (
        .clk (clk),
        .rst (rst),
        .bus (bus256)
    );

    int vectors = 0;
    int errors  = 0;

    logic       gold_in  [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    logic [1:0] gold_sym [6] = '{2'b11, 2'b10, 2'b00, 2'b01, 2'b01, 2'b11};

    // Reference symbol from the generator taps over {d, s[1], s[0]}
    function automatic logic [1:0] ref_sym(input logic d, input logic [1:0] s);
        logic [2:0] r;
        r = {d, s};
        return {^(r & 3'b111), ^(r & 3'b101)};
    endfunction

    // Advance one clock; inputs change and outputs are sampled on the falling edge
    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        bus4.start_i    = 1'b0;
        bus4.enable_i   = 1'b0;
        bus4.d_in       = 1'b0;
        bus256.start_i  = 1'b0;
        bus256.enable_i = 1'b0;
        bus256.d_in     = 1'b0;
    endtask

    task automatic check_zero4(input string name);
        vectors++;
        if ({bus4.ready_o, bus4.valid_o, bus4.d_out, bus4.last_o, bus4.busy_o,
             bus4.bit_ct_o} !== 22'd0) begin
            errors++;
            $display("FAIL %s: ready=%b valid=%b d_out=%b last=%b busy=%b bit_ct=%0d, expected all 0",
                     name, bus4.ready_o, bus4.valid_o, bus4.d_out, bus4.last_o,
                     bus4.busy_o, bus4.bit_ct_o);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus4.start_i    = 1'($urandom);
            bus4.enable_i   = 1'($urandom);
            bus4.d_in       = 1'($urandom);
            bus256.start_i  = 1'($urandom);
            bus256.enable_i = 1'($urandom);
            bus256.d_in     = 1'($urandom);
            cyc();
            check_zero4("reset_hold");
            vectors++;
            if ({bus256.ready_o, bus256.valid_o, bus256.d_out, bus256.last_o,
                 bus256.busy_o, bus256.bit_ct_o} !== 22'd0) begin
                errors++;
                $display("FAIL reset_hold256: valid=%b busy=%b bit_ct=%0d, expected all 0",
                         bus256.valid_o, bus256.busy_o, bus256.bit_ct_o);
            end
        end
        idle_inputs();
        rst = 1'b1;
        // Enable without start after release must not produce anything
        for (int i = 0; i < 3; i++) begin
            bus4.enable_i = 1'b1;
            bus4.d_in     = 1'($urandom);
            cyc();
            check_zero4("post_reset_idle");
        end
        idle_inputs();
    endtask

    // One FRAME_LEN=4 frame of the golden data; optional 3-cycle gap before bit 3
    // and optional noise on start_i/enable_i where they must be ignored.
    task automatic run_frame4(input string name, input bit gapped, input bit noisy);
        logic [1:0] held;
        bus4.start_i  = 1'b1;
        bus4.enable_i = noisy;
        bus4.d_in     = 1'b1;
        cyc();
        bus4.start_i = 1'b0;
        vectors++;
        if ({bus4.ready_o, bus4.busy_o, bus4.valid_o, bus4.bit_ct_o} !== {3'b110, 16'd0}) begin
            errors++;
            $display("FAIL %s_start: ready=%b busy=%b valid=%b bit_ct=%0d, expected 1 1 0 0",
                     name, bus4.ready_o, bus4.busy_o, bus4.valid_o, bus4.bit_ct_o);
        end
        for (int i = 0; i < 4; i++) begin
            if (gapped && i == 2) begin
                held = bus4.d_out;
                for (int g = 0; g < 3; g++) begin
                    bus4.enable_i = 1'b0;
                    bus4.d_in     = 1'($urandom);
                    bus4.start_i  = noisy;
                    cyc();
                    vectors++;
                    if (bus4.valid_o !== 1'b0 || bus4.d_out !== gold_sym[1] ||
                        bus4.bit_ct_o !== 16'd2) begin
                        errors++;
                        $display("FAIL %s_gap%0d: valid=%b d_out=%b bit_ct=%0d, expected 0 %b 2",
                                 name, g, bus4.valid_o, bus4.d_out, bus4.bit_ct_o, gold_sym[1]);
                    end
                end
                bus4.start_i = 1'b0;
                if (held !== gold_sym[1]) begin
                    vectors++;
                    errors++;
                    $display("FAIL %s_held: d_out=%b, expected %b", name, held, gold_sym[1]);
                end
            end
            bus4.enable_i = 1'b1;
            bus4.d_in     = gold_in[i];
            bus4.start_i  = noisy && (i == 1);
            cyc();
            bus4.start_i = 1'b0;
            vectors++;
            if (bus4.valid_o !== 1'b1 || bus4.d_out !== gold_sym[i] || bus4.last_o !== 1'b0 ||
                bus4.bit_ct_o !== 16'(i + 1)) begin
                errors++;
                $display("FAIL %s_sym%0d: valid=%b d_out=%b last=%b bit_ct=%0d, expected 1 %b 0 %0d",
                         name, i, bus4.valid_o, bus4.d_out, bus4.last_o, bus4.bit_ct_o,
                         gold_sym[i], i + 1);
            end
        end
        // Tail: data inputs must have no effect even when strobed
        bus4.enable_i = noisy;
        bus4.d_in     = noisy;
        for (int t = 0; t < 2; t++) begin
            cyc();
            vectors++;
            if (bus4.valid_o !== 1'b1 || bus4.d_out !== gold_sym[4 + t] ||
                bus4.last_o !== 1'(t == 1) || bus4.ready_o !== 1'b0 ||
                bus4.busy_o !== 1'(t == 0) || bus4.bit_ct_o !== 16'd4) begin
                errors++;
                $display("FAIL %s_tail%0d: valid=%b d_out=%b last=%b ready=%b busy=%b bit_ct=%0d, expected 1 %b %b 0 %b 4",
                         name, t, bus4.valid_o, bus4.d_out, bus4.last_o, bus4.ready_o,
                         bus4.busy_o, bus4.bit_ct_o, gold_sym[4 + t], 1'(t == 1), 1'(t == 0));
            end
        end
        cyc();
        vectors++;
        if (bus4.valid_o !== 1'b0 || bus4.last_o !== 1'b0 || bus4.d_out !== 2'b11 ||
            bus4.bit_ct_o !== 16'd4 || bus4.busy_o !== 1'b0) begin
            errors++;
            $display("FAIL %s_after: valid=%b last=%b d_out=%b bit_ct=%0d busy=%b, expected 0 0 11 4 0",
                     name, bus4.valid_o, bus4.last_o, bus4.d_out, bus4.bit_ct_o, bus4.busy_o);
        end
        idle_inputs();
    endtask

    task automatic test_golden();
        run_frame4("golden", 1'b0, 1'b0);
    endtask

    task automatic test_gapped();
        run_frame4("gapped", 1'b1, 1'b0);
    endtask

    task automatic test_ignored_controls();
        run_frame4("ignored", 1'b1, 1'b1);
    endtask

    task automatic test_mid_reset();
        bus4.start_i = 1'b1;
        cyc();
        bus4.start_i = 1'b0;
        for (int i = 0; i < 2; i++) begin
            bus4.enable_i = 1'b1;
            bus4.d_in     = gold_in[i];
            cyc();
        end
        bus4.enable_i = 1'b0;
        vectors++;
        if (bus4.valid_o !== 1'b1 || bus4.bit_ct_o !== 16'd2) begin
            errors++;
            $display("FAIL midrst_pre: valid=%b bit_ct=%0d, expected 1 2",
                     bus4.valid_o, bus4.bit_ct_o);
        end
        // Assert reset away from any clock edge: outputs must clear at once
        #2 rst = 1'b0;
        #1 check_zero4("midrst_async");
        cyc();
        rst = 1'b1;
        cyc();
        check_zero4("midrst_release");
        run_frame4("midrst_frame", 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back();
        logic [1:0] s;
        logic [1:0] exp;
        logic       d;
        int         last_cnt;
        last_cnt = 0;
        s        = 2'b00;
        bus256.start_i = 1'b1;
        cyc();
        bus256.start_i = 1'b0;
        for (int f = 0; f < 3; f++) begin
            for (int i = 0; i < 256; i++) begin
                d               = 1'($urandom);
                bus256.enable_i = 1'b1;
                bus256.d_in     = d;
                exp             = ref_sym(d, s);
                s               = {d, s[1]};
                cyc();
                if (bus256.last_o === 1'b1) last_cnt++;
                vectors++;
                if (bus256.valid_o !== 1'b1 || bus256.d_out !== exp || bus256.last_o !== 1'b0 ||
                    bus256.bit_ct_o !== 16'(i + 1)) begin
                    errors++;
                    $display("FAIL b2b_f%0d_sym%0d: valid=%b d_out=%b last=%b bit_ct=%0d, expected 1 %b 0 %0d",
                             f, i, bus256.valid_o, bus256.d_out, bus256.last_o,
                             bus256.bit_ct_o, exp, i + 1);
                end
            end
            bus256.enable_i = 1'b0;
            bus256.d_in     = 1'b0;
            for (int t = 0; t < 2; t++) begin
                exp = ref_sym(1'b0, s);
                s   = {1'b0, s[1]};
                cyc();
                if (bus256.last_o === 1'b1) last_cnt++;
                vectors++;
                if (bus256.valid_o !== 1'b1 || bus256.d_out !== exp ||
                    bus256.last_o !== 1'(t == 1) || bus256.bit_ct_o !== 16'd256) begin
                    errors++;
                    $display("FAIL b2b_f%0d_tail%0d: valid=%b d_out=%b last=%b bit_ct=%0d, expected 1 %b %b 256",
                             f, t, bus256.valid_o, bus256.d_out, bus256.last_o,
                             bus256.bit_ct_o, exp, 1'(t == 1));
                end
            end
            // Start in the cycle right after last_o
            bus256.start_i = (f < 2);
            cyc();
            bus256.start_i = 1'b0;
            s = 2'b00;
            if (bus256.last_o === 1'b1) last_cnt++;
            vectors++;
            if (bus256.valid_o !== 1'b0 || bus256.ready_o !== 1'(f < 2) ||
                bus256.bit_ct_o !== ((f < 2) ? 16'd0 : 16'd256)) begin
                errors++;
                $display("FAIL b2b_f%0d_restart: valid=%b ready=%b bit_ct=%0d, expected 0 %b %0d",
                         f, bus256.valid_o, bus256.ready_o, bus256.bit_ct_o, 1'(f < 2),
                         (f < 2) ? 0 : 256);
            end
        end
        vectors++;
        if (last_cnt !== 3) begin
            errors++;
            $display("FAIL b2b_last_count: last pulses=%0d, expected 3", last_cnt);
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        cyc();
        test_reset();
        test_golden();
        test_gapped();
        test_ignored_controls();
        test_mid_reset();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
